// File: rtl/rob_commit.sv
// In-order reorder buffer: dispatch, writeback marking, in-order retire, flush.
// Optional perf counters enabled by defining ROB_PERF_CNT_EN.
module rob_commit #(
  parameter int FETCH_W   = 2,
  parameter int ROB_DEPTH = 16,
  parameter int PHYS_REGS = 48,
  localparam int IW = $clog2(ROB_DEPTH),
  localparam int PW = $clog2(PHYS_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FETCH_W-1:0]            disp_valid,
  input  logic [FETCH_W-1:0]            disp_rd_valid,
  input  logic [FETCH_W-1:0][4:0]       disp_arch_rd,
  input  logic [FETCH_W-1:0][PW-1:0]    disp_phys_rd,
  input  logic [FETCH_W-1:0][31:0]      disp_pc,
  output logic                          disp_ready,
  output logic [FETCH_W-1:0][IW-1:0]    disp_rob_idx,
  input  logic [FETCH_W-1:0]            wb_valid,
  input  logic [FETCH_W-1:0][IW-1:0]    wb_rob_idx,
  input  logic [FETCH_W-1:0]            wb_mispredict,
  input  logic [FETCH_W-1:0][31:0]      wb_target,
  output logic [FETCH_W-1:0]            commit_en,
  output logic [FETCH_W-1:0][4:0]       commit_arch_rd,
  output logic [FETCH_W-1:0][PW-1:0]    commit_phys_rd,
  output logic                          flush_pipeline,
  output logic [31:0]                   flush_pc,
  output logic [IW:0]                   rob_count,
  output logic [31:0]                   perf_retired,
  output logic [31:0]                   perf_flushes
);

  localparam logic [IW:0] ONE = (IW+1)'(1);
  localparam logic [IW:0] DEP = (IW+1)'(ROB_DEPTH);
  localparam logic [IW:0] FW  = (IW+1)'(FETCH_W);

  logic [IW:0]                    cnt_q, cnt_d;
  logic [IW-1:0]                  head_q, head_d, tail_q, tail_d;
  logic [ROB_DEPTH-1:0]           vld_q, vld_d, done_q, done_d;
  logic [ROB_DEPTH-1:0]           misp_q, misp_d, rdv_q, rdv_d;
  logic [ROB_DEPTH-1:0][4:0]      arch_q, arch_d;
  logic [ROB_DEPTH-1:0][PW-1:0]   phys_q, phys_d;
  logic [ROB_DEPTH-1:0][31:0]     pc_q, pc_d, tgt_q, tgt_d;
  logic [FETCH_W-1:0]             cen_q, cen_d;
  logic [FETCH_W-1:0][4:0]        carch_q, carch_d;
  logic [FETCH_W-1:0][PW-1:0]     cphys_q, cphys_d;
  logic                           flush_q, flush_d;
  logic [31:0]                    fpc_q, fpc_d;
  logic [IW:0]                    n_ret, n_disp;
  logic [IW-1:0]                  idx, slot;
  logic                           go, acc;
  logic                           unused_pc;

  assign unused_pc = ^pc_q;

  always_comb begin
    vld_d   = vld_q;
    done_d  = done_q;
    misp_d  = misp_q;
    rdv_d   = rdv_q;
    arch_d  = arch_q;
    phys_d  = phys_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    cen_d   = '0;
    carch_d = '0;
    cphys_d = '0;
    flush_d = 1'b0;
    fpc_d   = fpc_q;
    n_ret   = '0;
    n_disp  = '0;
    go      = 1'b1;
    idx     = '0;
    // retire scan stops at the first not-done entry or a mispredict
    for (int k = 0; k < FETCH_W; k++) begin
      idx = head_q + IW'(k);
      if (go && vld_q[idx] && done_q[idx]) begin
        vld_d[idx] = 1'b0;
        cen_d[k]   = rdv_q[idx];
        carch_d[k] = arch_q[idx];
        cphys_d[k] = phys_q[idx];
        n_ret      = n_ret + ONE;
        if (misp_q[idx]) begin
          flush_d = 1'b1;
          fpc_d   = tgt_q[idx];
          go      = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
    for (int p = 0; p < FETCH_W; p++) begin
      if (wb_valid[p] && vld_q[wb_rob_idx[p]]) begin
        done_d[wb_rob_idx[p]] = 1'b1;
        misp_d[wb_rob_idx[p]] = wb_mispredict[p];
        tgt_d[wb_rob_idx[p]]  = wb_target[p];
      end
    end
    disp_ready = ((DEP - cnt_q) >= FW) && !flush_q;
    acc        = disp_ready && !flush_d;
    slot       = tail_q;
    for (int k = 0; k < FETCH_W; k++) begin
      disp_rob_idx[k] = slot;
      if (disp_valid[k]) begin
        if (acc) begin
          vld_d[slot]  = 1'b1;
          done_d[slot] = 1'b0;
          misp_d[slot] = 1'b0;
          rdv_d[slot]  = disp_rd_valid[k];
          arch_d[slot] = disp_arch_rd[k];
          phys_d[slot] = disp_phys_rd[k];
          pc_d[slot]   = disp_pc[k];
          n_disp       = n_disp + ONE;
        end
        slot = slot + IW'(1);
      end
    end
    head_d = head_q + n_ret[IW-1:0];
    tail_d = tail_q + n_disp[IW-1:0];
    cnt_d  = cnt_q + n_disp - n_ret;
    if (flush_d) begin
      vld_d  = '0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      vld_q   <= '0;
      done_q  <= '0;
      misp_q  <= '0;
      rdv_q   <= '0;
      arch_q  <= '0;
      phys_q  <= '0;
      pc_q    <= '0;
      tgt_q   <= '0;
      cen_q   <= '0;
      carch_q <= '0;
      cphys_q <= '0;
      flush_q <= 1'b0;
      fpc_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      misp_q  <= misp_d;
      rdv_q   <= rdv_d;
      arch_q  <= arch_d;
      phys_q  <= phys_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cen_q   <= cen_d;
      carch_q <= carch_d;
      cphys_q <= cphys_d;
      flush_q <= flush_d;
      fpc_q   <= fpc_d;
    end
  end

  assign commit_en      = cen_q;
  assign commit_arch_rd = carch_q;
  assign commit_phys_rd = cphys_q;
  assign flush_pipeline = flush_q;
  assign flush_pc       = fpc_q;
  assign rob_count      = cnt_q;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] pret_q, pret_d, pfl_q, pfl_d;

  always_comb begin
    pret_d = pret_q + 32'(n_ret);
    pfl_d  = pfl_q + {31'd0, flush_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pret_q <= '0;
      pfl_q  <= '0;
    end else begin
      pret_q <= pret_d;
      pfl_q  <= pfl_d;
    end
  end

  assign perf_retired = pret_q;
  assign perf_flushes = pfl_q;
`else
  assign perf_retired = '0;
  assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Random + directed bench for rob_commit against a queue-based ROB model.
// Honors ROB_PERF_CNT_EN for the perf counter expectations.
module tb_rob_commit;

  localparam int FW  = 2;
  localparam int DEP = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        disp_valid, disp_rd_valid;
  logic [1:0][4:0]   disp_arch_rd;
  logic [1:0][5:0]   disp_phys_rd;
  logic [1:0][31:0]  disp_pc;
  logic              disp_ready;
  logic [1:0][3:0]   disp_rob_idx;
  logic [1:0]        wb_valid, wb_mispredict;
  logic [1:0][3:0]   wb_rob_idx;
  logic [1:0][31:0]  wb_target;
  logic [1:0]        commit_en;
  logic [1:0][4:0]   commit_arch_rd;
  logic [1:0][5:0]   commit_phys_rd;
  logic              flush_pipeline;
  logic [31:0]       flush_pc;
  logic [4:0]        rob_count;
  logic [31:0]       perf_retired, perf_flushes;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_rd_valid(disp_rd_valid),
    .disp_arch_rd(disp_arch_rd), .disp_phys_rd(disp_phys_rd),
    .disp_pc(disp_pc), .disp_ready(disp_ready),
    .disp_rob_idx(disp_rob_idx), .wb_valid(wb_valid),
    .wb_rob_idx(wb_rob_idx), .wb_mispredict(wb_mispredict),
    .wb_target(wb_target), .commit_en(commit_en),
    .commit_arch_rd(commit_arch_rd), .commit_phys_rd(commit_phys_rd),
    .flush_pipeline(flush_pipeline), .flush_pc(flush_pc),
    .rob_count(rob_count), .perf_retired(perf_retired),
    .perf_flushes(perf_flushes)
  );

  typedef struct {
    logic [3:0]  idx;
    bit          done;
    bit          misp;
    bit          rdv;
    logic [4:0]  arch;
    logic [5:0]  phys;
    logic [31:0] tgt;
  } ent_t;

  ent_t            rob[$];
  int              m_head;
  int              n_vec, n_err;
  logic [1:0]      e_cen;
  logic [1:0][4:0] e_arch;
  logic [1:0][5:0] e_phys;
  logic            e_flush;
  logic [31:0]     e_fpc;
  int              tot_ret, tot_fl;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rob.delete();
    m_head  = 0;
    e_cen   = '0;
    e_arch  = '0;
    e_phys  = '0;
    e_flush = 1'b0;
    e_fpc   = '0;
    tot_ret = 0;
    tot_fl  = 0;
  endtask

  task automatic idle();
    disp_valid    = '0;
    disp_rd_valid = '0;
    disp_arch_rd  = '0;
    disp_phys_rd  = '0;
    disp_pc       = '0;
    wb_valid      = '0;
    wb_rob_idx    = '0;
    wb_mispredict = '0;
    wb_target     = '0;
  endtask

  task automatic check_outs();
    int tl;
    tl = (m_head + rob.size()) % DEP;
    chk("rob_count", 64'(rob_count), 64'(rob.size()));
    chk("disp_ready", 64'(disp_ready),
        64'((DEP - rob.size() >= FW) && !e_flush));
    chk("idx0", 64'(disp_rob_idx[0]), 64'(tl));
    chk("idx1", 64'(disp_rob_idx[1]), 64'((tl + int'(disp_valid[0])) % DEP));
    chk("commit_en", 64'(commit_en), 64'(e_cen));
    chk("commit_arch", 64'(commit_arch_rd), 64'(e_arch));
    chk("commit_phys", 64'(commit_phys_rd), 64'(e_phys));
    chk("flush", 64'(flush_pipeline), 64'(e_flush));
    if (e_flush) chk("flush_pc", 64'(flush_pc), 64'(e_fpc));
`ifdef ROB_PERF_CNT_EN
    chk("perf_ret", 64'(perf_retired), 64'(tot_ret));
    chk("perf_fl", 64'(perf_flushes), 64'(tot_fl));
`else
    chk("perf_ret", 64'(perf_retired), 64'd0);
    chk("perf_fl", 64'(perf_flushes), 64'd0);
`endif
  endtask

  // One clock edge of the reference ROB, applied to the current inputs.
  task automatic model_edge();
    bit          rdy;
    int          nr;
    bit          fl;
    logic [31:0] ft;
    ent_t        e;
    rdy = (DEP - rob.size() >= FW) && !e_flush;
    nr  = 0;
    fl  = 0;
    ft  = e_fpc;
    e_cen  = '0;
    e_arch = '0;
    e_phys = '0;
    for (int k = 0; k < FW; k++) begin
      if (k >= rob.size() || !rob[k].done) break;
      e_cen[k]  = rob[k].rdv;
      e_arch[k] = rob[k].arch;
      e_phys[k] = rob[k].phys;
      nr++;
      if (rob[k].misp) begin
        fl = 1;
        ft = rob[k].tgt;
        break;
      end
    end
    for (int p = 0; p < FW; p++)
      if (wb_valid[p])
        foreach (rob[i])
          if (rob[i].idx == wb_rob_idx[p]) begin
            rob[i].done = 1;
            rob[i].misp = wb_mispredict[p];
            rob[i].tgt  = wb_target[p];
          end
    repeat (nr) void'(rob.pop_front());
    m_head  = (m_head + nr) % DEP;
    tot_ret += nr;
    if (fl) begin
      rob.delete();
      m_head = 0;
      tot_fl++;
    end else if (rdy) begin
      for (int k = 0; k < FW; k++)
        if (disp_valid[k]) begin
          e.idx  = 4'((m_head + rob.size()) % DEP);
          e.done = 0;
          e.misp = 0;
          e.rdv  = disp_rd_valid[k];
          e.arch = disp_arch_rd[k];
          e.phys = disp_phys_rd[k];
          e.tgt  = '0;
          rob.push_back(e);
        end
    end
    e_flush = fl;
    if (fl) e_fpc = ft;
  endtask

  task automatic step();
    #1;
    check_outs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rst_chk();
    chk("rst_cen", 64'(commit_en), 64'd0);
    chk("rst_arch", 64'(commit_arch_rd), 64'd0);
    chk("rst_phys", 64'(commit_phys_rd), 64'd0);
    chk("rst_flush", 64'(flush_pipeline), 64'd0);
    chk("rst_fpc", 64'(flush_pc), 64'd0);
    chk("rst_cnt", 64'(rob_count), 64'd0);
    chk("rst_rdy", 64'(disp_ready), 64'd1);
    chk("rst_pret", 64'(perf_retired), 64'd0);
    chk("rst_pfl", 64'(perf_flushes), 64'd0);
  endtask

  task automatic set_disp(logic [1:0] v, logic [1:0] rv,
                          logic [4:0] a0, logic [5:0] p0,
                          logic [4:0] a1, logic [5:0] p1);
    disp_valid      = v;
    disp_rd_valid   = rv;
    disp_arch_rd[0] = a0;
    disp_phys_rd[0] = p0;
    disp_arch_rd[1] = a1;
    disp_phys_rd[1] = p1;
    disp_pc[0]      = $urandom;
    disp_pc[1]      = $urandom;
  endtask

  task automatic set_wb(int p, logic [3:0] i, bit m, logic [31:0] t);
    wb_valid[p]      = 1'b1;
    wb_rob_idx[p]    = i;
    wb_mispredict[p] = m;
    wb_target[p]     = t;
  endtask

  task automatic rand_disp(int pct);
    disp_valid    = ($urandom_range(99) < pct) ? 2'($urandom_range(1, 3)) : 2'b00;
    disp_rd_valid = 2'($urandom);
    for (int k = 0; k < FW; k++) begin
      disp_arch_rd[k] = 5'($urandom);
      disp_phys_rd[k] = 6'($urandom_range(47));
      disp_pc[k]      = $urandom;
    end
  endtask

  task automatic rand_wb(int mp);
    wb_valid      = '0;
    wb_rob_idx    = '0;
    wb_mispredict = '0;
    wb_target     = '0;
    for (int p = 0; p < FW; p++) begin
      int r;
      r = $urandom_range(99);
      if (r < 70) begin
        int cand[$];
        foreach (rob[i]) if (!rob[i].done) cand.push_back(i);
        if (cand.size() > 0) begin
          int c;
          c = cand[$urandom_range(cand.size() - 1)];
          set_wb(p, rob[c].idx, $urandom_range(99) < mp, $urandom);
        end
      end else if (r < 80 && rob.size() < DEP) begin
        logic [3:0] j;
        bit         hit;
        j   = 4'($urandom_range(15));
        hit = 0;
        foreach (rob[i]) if (rob[i].idx == j) hit = 1;
        if (!hit) set_wb(p, j, 1'b0, $urandom);
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (rob.size() > 0 && guard < 200) begin
      idle();
      rand_wb(0);
      step();
      guard++;
    end
    idle();
    step();
    chk("drain", 64'(rob_count), 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    idle();
    model_reset();
    #2;
    rst_chk();
    @(negedge clk);
    reset = 1'b1;

    // basic two-lane commit
    set_disp(2'b11, 2'b11, 5'd3, 6'd33, 5'd4, 6'd34);
    step();
    idle();
    set_wb(0, 4'd0, 1'b0, 32'd0);
    set_wb(1, 4'd1, 1'b0, 32'd0);
    step();
    idle();
    step();
    chk("t1_cen", 64'(commit_en), 64'd3);
    chk("t1_arch", 64'(commit_arch_rd), 64'({5'd4, 5'd3}));
    chk("t1_phys", 64'(commit_phys_rd), 64'({6'd34, 6'd33}));
    chk("t1_cnt", 64'(rob_count), 64'd0);

    // fill to full, tail wraps
    for (int g = 0; g < 8; g++) begin
      rand_disp(100);
      disp_valid = 2'b11;
      step();
      if (g == 6) chk("tail_wrap", 64'(disp_rob_idx[0]), 64'd0);
    end
    idle();
    chk("full_cnt", 64'(rob_count), 64'd16);
    chk("full_rdy", 64'(disp_ready), 64'd0);
    rand_disp(100);
    step();
    idle();
    set_wb(0, rob[0].idx, 1'b0, 32'd0);
    step();
    idle();
    step();
    chk("f15_cnt", 64'(rob_count), 64'd15);
    chk("f15_rdy", 64'(disp_ready), 64'd0);
    set_wb(1, rob[0].idx, 1'b0, 32'd0);
    step();
    idle();
    step();
    chk("f14_rdy", 64'(disp_ready), 64'd1);
    drain();

    // out-of-order completion
    set_disp(2'b11, 2'b11, 5'd7, 6'd10, 5'd8, 6'd11);
    step();
    idle();
    set_wb(0, rob[1].idx, 1'b0, 32'd0);
    step();
    idle();
    step();
    chk("ooo_cen", 64'(commit_en), 64'd0);
    chk("ooo_cnt", 64'(rob_count), 64'd2);
    set_wb(1, rob[0].idx, 1'b0, 32'd0);
    step();
    idle();
    step();
    chk("ooo_cen2", 64'(commit_en), 64'd3);
    chk("ooo_arch", 64'(commit_arch_rd), 64'({5'd8, 5'd7}));

    // store without a destination
    set_disp(2'b01, 2'b00, 5'd9, 6'd12, 5'd0, 6'd0);
    step();
    idle();
    set_wb(0, rob[0].idx, 1'b0, 32'd0);
    step();
    idle();
    step();
    chk("st_cen", 64'(commit_en), 64'd0);
    chk("st_cnt", 64'(rob_count), 64'd0);

    // asynchronous reset with six live entries
    for (int g = 0; g < 3; g++) begin
      rand_disp(100);
      disp_valid = 2'b11;
      step();
    end
    idle();
    set_wb(0, rob[0].idx, 1'b0, 32'd0);
    step();
    idle();
    #2;
    reset = 1'b0;
    #1;
    rst_chk();
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // mispredicted branch at index 2
    set_disp(2'b11, 2'b11, 5'd1, 6'd1, 5'd2, 6'd2);
    #1;
    chk("post_rst_idx0", 64'(disp_rob_idx[0]), 64'd0);
    step();
    set_disp(2'b11, 2'b11, 5'd3, 6'd3, 5'd4, 6'd4);
    step();
    set_disp(2'b11, 2'b11, 5'd5, 6'd5, 5'd6, 6'd6);
    step();
    idle();
    set_wb(0, 4'd3, 1'b0, 32'd0);
    set_wb(1, 4'd4, 1'b0, 32'd0);
    step();
    idle();
    set_wb(0, 4'd5, 1'b0, 32'd0);
    step();
    idle();
    set_wb(0, 4'd0, 1'b0, 32'd0);
    set_wb(1, 4'd1, 1'b0, 32'd0);
    step();
    idle();
    set_wb(1, 4'd2, 1'b1, 32'h0000_0400);
    step();
    idle();
    set_disp(2'b11, 2'b11, 5'd20, 6'd20, 5'd21, 6'd21);
    step();
    chk("br_flush", 64'(flush_pipeline), 64'd1);
    chk("br_fpc", 64'(flush_pc), 64'h400);
    chk("br_cen", 64'(commit_en), 64'd1);
    chk("br_arch0", 64'(commit_arch_rd[0]), 64'd3);
    chk("br_cnt", 64'(rob_count), 64'd0);
    step();
    chk("br_flush2", 64'(flush_pipeline), 64'd0);
    chk("br_cen2", 64'(commit_en), 64'd0);
    chk("br_cnt2", 64'(rob_count), 64'd0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rand_disp(60);
      rand_wb(8);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
